visor_step_sequencer: RTL

- Hardware sequencer that the debug supervisor MCU uses to halt, single-step and inject instructions into the target Synapse316.
- It drives the target's debug-control inputs and diverts the target's code bus.
- For an injection it loads the injected instruction, executes it, captures the target-to-visor register, then restores the original EXR contents.
- It sits between the supervisor's register file, the target MCU and the target code ROM mux, and replaces firmware bit-banging of those controls.

---
 rtl/visor_step_sequencer.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/visor_step_sequencer.sv
// Debug sequencer for the Synapse316 target: halt, single-step and instruction injection
// with EXR restore, driving the target debug controls and the diverted code bus.
module visor_step_sequencer #(
    parameter int TIMEOUT_W    = 8,
    parameter int STEP_TIMEOUT = 200,
    parameter int CAPTURE_LAT  = 2
) (
    input  logic        sysclk,
    input  logic        sysreset,
    input  logic        cmd_valid,
    input  logic [1:0]  cmd_op,
    input  logic [15:0] cmd_instr,
    output logic        cmd_ready,
    output logic        done,
    output logic        err,
    output logic        halted,
    output logic        halted_evt,
    output logic [15:0] result,
    input  logic        bp_hit,
    input  logic [15:0] exr_shadow,
    input  logic [1:0]  tg_debug_out,
    input  logic [15:0] tg_to_visor_reg,
    output logic [2:0]  tg_debug_in,
    output logic        divert,
    output logic [15:0] code_out,
    output logic        code_ready_out
);

    if (STEP_TIMEOUT < 1 || STEP_TIMEOUT >= 2 ** TIMEOUT_W) begin : g_bad_step_timeout
        $error("STEP_TIMEOUT must be in 1..2**TIMEOUT_W-1");
    end
    if (CAPTURE_LAT < 1 || CAPTURE_LAT >= 2 ** TIMEOUT_W) begin : g_bad_capture_lat
        $error("CAPTURE_LAT must be in 1..2**TIMEOUT_W-1");
    end

    localparam logic [TIMEOUT_W-1:0] STEP_LIM = TIMEOUT_W'(STEP_TIMEOUT);
    localparam logic [TIMEOUT_W-1:0] CAP_LIM  = TIMEOUT_W'(CAPTURE_LAT);

    typedef enum logic [2:0] {
        ST_RUN, ST_HALTED, ST_INJ_LOAD, ST_INJ_EXEC,
        ST_INJ_CAP, ST_INJ_RESTORE, ST_STEP_REL, ST_STEP_WAIT
    } state_t;

    typedef enum logic [1:0] {OP_HALT, OP_RESUME, OP_STEP, OP_INJECT} op_t;

    state_t               r_state, w_state_nxt;
    logic [TIMEOUT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
    logic [15:0]          r_instr, w_instr_nxt;
    logic [15:0]          r_result, w_result_nxt;
    logic                 r_done, w_done_nxt;
    logic                 r_err, w_err_nxt;
    logic                 r_evt, w_evt_nxt;
    logic                 w_accept;
    logic                 w_hold, w_force_exec, w_force_load;
    op_t                  w_op;
    logic                 w_unused;

    assign w_unused  = tg_debug_out[1];
    assign w_op      = op_t'(cmd_op);
    assign cmd_ready = (r_state == ST_RUN) || (r_state == ST_HALTED);
    assign w_accept  = cmd_valid && cmd_ready;
    assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + TIMEOUT_W'(1);

    always_ff @(posedge sysclk) begin
        if (sysreset) begin
            r_state  <= ST_RUN;
            r_cnt    <= '0;
            r_instr  <= '0;
            r_result <= '0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_evt    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_instr  <= w_instr_nxt;
            r_result <= w_result_nxt;
            r_done   <= w_done_nxt;
            r_err    <= w_err_nxt;
            r_evt    <= w_evt_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_instr_nxt  = r_instr;
        w_result_nxt = r_result;
        w_done_nxt   = 1'b0;
        w_err_nxt    = 1'b0;
        w_evt_nxt    = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (bp_hit) begin
                    w_state_nxt = ST_HALTED;
                    w_evt_nxt   = 1'b1;
                end
                // Only HALT is legal while running; anything else is rejected with err.
                if (w_accept) begin
                    w_done_nxt = 1'b1;
                    if (w_op == OP_HALT) w_state_nxt = ST_HALTED;
                    else                 w_err_nxt   = 1'b1;
                end
            end
            ST_HALTED: begin
                if (w_accept) begin
                    case (w_op)
                        OP_HALT:   w_done_nxt = 1'b1;
                        OP_RESUME: begin
                            w_done_nxt  = 1'b1;
                            w_state_nxt = ST_RUN;
                        end
                        OP_STEP:   w_state_nxt = ST_STEP_REL;
                        default: begin
                            w_state_nxt = ST_INJ_LOAD;
                            w_instr_nxt = cmd_instr;
                        end
                    endcase
                end
            end
            ST_STEP_REL: begin
                w_state_nxt = ST_STEP_WAIT;
                w_cnt_nxt   = '0;
            end
            ST_STEP_WAIT: begin
                if (tg_debug_out[0]) begin
                    w_state_nxt = ST_HALTED;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                    if (w_cnt_inc == STEP_LIM) begin
                        w_state_nxt = ST_HALTED;
                        w_done_nxt  = 1'b1;
                        w_err_nxt   = 1'b1;
                    end
                end
            end
            ST_INJ_LOAD: w_state_nxt = ST_INJ_EXEC;
            ST_INJ_EXEC: begin
                w_state_nxt = ST_INJ_CAP;
                w_cnt_nxt   = '0;
            end
            ST_INJ_CAP: begin
                w_cnt_nxt = w_cnt_inc;
                if (w_cnt_inc == CAP_LIM) begin
                    w_result_nxt = tg_to_visor_reg;
                    w_state_nxt  = ST_INJ_RESTORE;
                end
            end
            ST_INJ_RESTORE: begin
                w_state_nxt = ST_HALTED;
                w_done_nxt  = 1'b1;
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    always_comb begin
        w_hold         = 1'b0;
        w_force_exec   = 1'b0;
        w_force_load   = 1'b0;
        divert         = 1'b0;
        code_out       = '0;
        code_ready_out = 1'b0;
        case (r_state)
            ST_HALTED, ST_STEP_WAIT: w_hold = 1'b1;
            ST_INJ_LOAD: begin
                w_hold         = 1'b1;
                w_force_load   = 1'b1;
                divert         = 1'b1;
                code_out       = r_instr;
                code_ready_out = 1'b1;
            end
            ST_INJ_EXEC: begin
                w_hold       = 1'b1;
                w_force_exec = 1'b1;
                divert       = 1'b1;
            end
            ST_INJ_CAP: begin
                w_hold = 1'b1;
                divert = 1'b1;
            end
            ST_INJ_RESTORE: begin
                w_hold         = 1'b1;
                w_force_load   = 1'b1;
                divert         = 1'b1;
                code_out       = exr_shadow;
                code_ready_out = 1'b1;
            end
            default: ;
        endcase
    end

    assign tg_debug_in = {w_force_exec, w_force_load, w_hold};
    assign halted      = w_hold;
    assign done        = r_done;
    assign err         = r_err;
    assign halted_evt  = r_evt;
    assign result      = r_result;

endmodule
